alu_mul_booth_seq: RTL and testbench

//   Iterative signed multiplier (radix-2 Booth), one Booth step per clock.

---
 rtl/alu_mul_booth_seq_pkg.sv | 29 ++
 rtl/alu_mul_booth_seq_booth_step.sv | 41 ++++
 rtl/alu_mul_booth_seq.sv | 104 ++++++++++
 tb/tb_alu_mul_booth_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_mul_booth_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encodings, default operand width and the Booth recoding helper.
package alu_mul_booth_seq_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the multiplier bit pair {Q[0], q_m1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_booth_seq_booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into
// acc, then arithmetic right shift of {acc, Q, q_m1} by one bit.
module f_booth_step
  import alu_mul_booth_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH:0]   acc,
  input  logic        [DATA_WIDTH-1:0] q,
  input  logic                         q_m1,
  input  logic signed [DATA_WIDTH:0]   m,
  output logic signed [DATA_WIDTH:0]   acc_next,
  output logic        [DATA_WIDTH-1:0] q_next,
  output logic                         q_m1_next
);

  booth_op_t                 op;
  logic signed [DATA_WIDTH:0] addend;
  logic signed [DATA_WIDTH:0] sum;
  logic                       carry_in;

  // Subtraction is ~M plus a carry-in of one; acc is N+1 bits so -M never overflows.
  always_comb begin
    op       = booth_decode(q[0], q_m1);
    addend   = '0;
    carry_in = 1'b0;
    case (op)
      OP_ADD: addend = m;
      OP_SUB: begin
        addend   = ~m;
        carry_in = 1'b1;
      end
      default: ;
    endcase
    sum       = acc + addend + {{DATA_WIDTH{1'b0}}, carry_in};
    acc_next  = {sum[DATA_WIDTH], sum[DATA_WIDTH:1]};
    q_next    = {sum[0], q[DATA_WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/alu_mul_booth_seq.sv
// Iterative signed multiplier, one radix-2 Booth step per clock.
// start/busy/done handshake; Z holds the 2N-bit product until the next completion.
module alu_mul_booth_seq
  import alu_mul_booth_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   Z
);

  localparam int            CW   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  mul_state_t state, state_next;
  logic       load, finish;

  logic [CW-1:0]              count;
  logic signed [DATA_WIDTH:0] m_reg, acc_reg, acc_step;
  logic [DATA_WIDTH-1:0]      q_reg, q_step;
  logic                       q_m1_reg, q_m1_step;

  f_booth_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .acc       (acc_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .m         (m_reg),
    .acc_next  (acc_step),
    .q_next    (q_step),
    .q_m1_next (q_m1_step)
  );

  // State register; clear wins over everything, abandoning any run in flight.
  always_ff @(posedge clock) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus the load/finish strobes; start is only heard in IDLE or DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (count == LAST) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Step counter and result register; Z only moves on DONE entry or clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      count <= '0;
      Z     <= '0;
    end else begin
      if (load)                 count <= '0;
      else if (state == ST_RUN) count <= count + 1'b1;
      if (finish) Z <= {acc_step[DATA_WIDTH-1:0], q_step};
    end
  end

  // Working registers: loaded on an accepted start, advanced once per RUN cycle.
  always_ff @(posedge clock) begin
    if (load) begin
      m_reg    <= {A[DATA_WIDTH-1], A};
      acc_reg  <= '0;
      q_reg    <= B;
      q_m1_reg <= 1'b0;
    end else if (state == ST_RUN) begin
      acc_reg  <= acc_step;
      q_reg    <= q_step;
      q_m1_reg <= q_m1_step;
    end
  end

endmodule

// File: tb/tb_alu_mul_booth_seq.sv
// Directed and random checks for the sequential Booth multiplier.
module tb_alu_mul_booth_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [63:0] Z;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  alu_mul_booth_seq #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) check("busy_done_exclusive", 64'(busy & done), 64'd0);
  end

  // Start one multiply, optionally pulse a second start mid-run at step inject_at.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag, input int inject_at);
    int busy_cnt;
    bit got_done;
    busy_cnt = 0;
    got_done = 1'b0;
    @(negedge clock);
    A = a; B = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (c == inject_at) begin
        A = 32'd2; B = 32'd2; start = 1'b1;
      end else if (c == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_z"}, Z, exp);
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_z_held"}, Z, exp);
  endtask

  initial begin
    int nd, first_c, second_c;
    logic [31:0]        ra, rb;
    logic signed [63:0] sa, sb, sp;

    vecs[0] = '{32'd6,         32'd7,         64'h0000_0000_0000_002A, "v_6x7"};
    vecs[1] = '{32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "v_m3x5"};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "v_min_min"};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "v_min_m1"};
    vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "v_max_max"};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "v_max_min"};
    vecs[6] = '{32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000, "v_zero"};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "v_m1_m1"};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_z", Z, 64'd0);
    clear  = 1'b1;
    mon_en = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) run_mul(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].name, -1);

    // Start during RUN is ignored
    run_mul(32'd6, 32'd7, 64'd42, "ignore_start", 10);

    // Clear mid-run abandons the operation
    @(negedge clock);
    A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    check("midrun_clear_busy", 64'(busy), 64'd0);
    check("midrun_clear_done", 64'(done), 64'd0);
    check("midrun_clear_z", Z, 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("midrun_clear_no_done", 64'(nd), 64'd0);
    check("midrun_clear_z_stays", Z, 64'd0);
    run_mul(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "after_clear", -1);

    // Back-to-back: start held through DONE
    @(negedge clock);
    A = 32'd9; B = 32'hFFFF_FFF7; start = 1'b1;
    nd = 0; first_c = -1; second_c = -1;
    for (int c = 0; c < 80 && nd < 2; c++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        check("b2b_z", Z, 64'hFFFF_FFFF_FFFF_FFAF);
        if (nd == 1) first_c = c;
        else begin
          second_c = c;
          start    = 1'b0;
        end
      end
    end
    check("b2b_done_count", 64'(nd), 64'd2);
    check("b2b_restart_gap", 64'(second_c - first_c), 64'd33);
    @(negedge clock);
    check("b2b_idle_busy", 64'(busy), 64'd0);
    check("b2b_idle_done", 64'(done), 64'd0);

    // Random signed pairs against a reference product
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'h8000_0000;
      if (i % 70 == 1) rb = 32'hFFFF_FFFF;
      sa = {{32{ra[31]}}, ra};
      sb = {{32{rb[31]}}, rb};
      sp = sa * sb;
      run_mul(ra, rb, sp, "rand", -1);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
